rmc_speed_sequencer: RTL

//  Byte-serial NMEA RMC front end that sequences speed_extract. It parses the UART byte

---
 rtl/rmc_speed_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rmc_speed_sequencer.sv
// rmc_speed_sequencer: byte-serial NMEA RMC front end for speed_extract.
// Parses "$GPRMC"/"$GNRMC" sentences and normalises the speed field to
// "<int>.<2 frac>". It checks status and checksum, then hands the speed
// characters to speed_extract with a new_fix pulse and waits for speed_valid.
module rmc_speed_sequencer #(
  parameter int ACK_TIMEOUT = 4,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              speed_valid,
  output logic [7:0]        spd0,
  output logic [7:0]        spd1,
  output logic [7:0]        spd2,
  output logic [7:0]        spd3,
  output logic [7:0]        spd4,
  output logic [7:0]        spd5,
  output logic [3:0]        speed_len,
  output logic              new_fix,
  output logic              busy,
  output logic              ack_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, FIELDS, CK1, CK2, ISSUE, WAIT_ACK} state_t;

  state_t          state, next_state;
  logic            drop;
  logic [TW-1:0]   timer;
  logic [7:0]      ck_xor;
  logic [3:0]      ck_hi;
  logic [3:0]      comma_cnt;
  logic [2:0]      hdr_idx;
  logic            reject;
  logic            status_ok;
  logic [1:0]      int_cnt;
  logic [1:0]      frac_cnt;
  logic            seen_dot;
  logic [7:0]      shadow [8];
  logic [3:0]      shadow_len;

  logic            parse_state;
  logic            byte_dollar;
  logic            restart;
  logic            ck_match;
  logic [2:0]      int_pos;
  logic [2:0]      frac_pos;

  // Header position check: "G", "P" or "N", "R", "M", "C".
  function automatic logic hdr_match(input logic [2:0] idx, input logic [7:0] b);
    case (idx)
      3'd0:    return b == "G";
      3'd1:    return (b == "P") || (b == "N");
      3'd2:    return b == "R";
      3'd3:    return b == "M";
      3'd4:    return b == "C";
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= "0") && (b <= "9");
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return is_digit(b) || ((b >= "A") && (b <= "F")) || ((b >= "a") && (b <= "f"));
  endfunction

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return is_digit(b) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  assign parse_state = (state != ISSUE) && (state != WAIT_ACK);
  assign byte_dollar = rx_valid && (rx_data == "$");
  assign restart     = byte_dollar && parse_state;
  assign ck_match    = ({ck_hi, hex_val(rx_data)} == ck_xor);
  assign int_pos     = {1'b0, int_cnt};
  assign frac_pos    = int_pos + 3'd1 + {1'b0, frac_cnt};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode plus the handshake strobes and drop request.
  always_comb begin
    next_state = state;
    drop       = 1'b0;
    new_fix    = 1'b0;
    busy       = 1'b0;
    ack_err    = 1'b0;
    case (state)
      IDLE: begin
        if (byte_dollar) next_state = HDR;
      end
      HDR: begin
        if (byte_dollar) begin
          drop       = 1'b1;
          next_state = HDR;
        end else if (rx_valid) begin
          if (!hdr_match(hdr_idx, rx_data)) begin
            drop       = 1'b1;
            next_state = IDLE;
          end else if (hdr_idx == 3'd4) begin
            next_state = FIELDS;
          end
        end
      end
      FIELDS: begin
        if (byte_dollar) begin
          drop       = 1'b1;
          next_state = HDR;
        end else if (rx_valid && (rx_data == "*")) begin
          next_state = CK1;
        end
      end
      CK1: begin
        if (byte_dollar) begin
          drop       = 1'b1;
          next_state = HDR;
        end else if (rx_valid) begin
          next_state = CK2;
        end
      end
      CK2: begin
        if (byte_dollar) begin
          drop       = 1'b1;
          next_state = HDR;
        end else if (rx_valid) begin
          if (!reject && is_hex(rx_data) && ck_match) begin
            next_state = ISSUE;
          end else begin
            drop       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISSUE: begin
        new_fix    = 1'b1;
        busy       = 1'b1;
        next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (speed_valid) begin
          next_state = IDLE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          ack_err    = rst;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Sentence parser: checksum, comma tracking, status and speed normalisation.
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      ck_xor     <= 8'h00;
      ck_hi      <= 4'h0;
      comma_cnt  <= 4'd0;
      hdr_idx    <= 3'd0;
      reject     <= 1'b0;
      status_ok  <= 1'b0;
      int_cnt    <= 2'd0;
      frac_cnt   <= 2'd0;
      seen_dot   <= 1'b0;
      shadow_len <= 4'd0;
      for (int i = 0; i < 8; i++) shadow[i] <= 8'h2E;
    end else if (rx_valid) begin
      case (state)
        HDR: begin
          ck_xor  <= ck_xor ^ rx_data;
          hdr_idx <= hdr_idx + 3'd1;
        end
        FIELDS: begin
          if (rx_data == "*") begin
            if ((comma_cnt < 4'd8) || !status_ok) reject <= 1'b1;
          end else begin
            ck_xor <= ck_xor ^ rx_data;
            if (rx_data == ",") begin
              if (comma_cnt != 4'd15) comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt == 4'd7) begin
                if (int_cnt == 2'd0) reject <= 1'b1;
                if (frac_cnt == 2'd0) shadow[int_pos + 3'd1] <= "0";
                if (frac_cnt != 2'd2) shadow[int_pos + 3'd2] <= "0";
                shadow_len <= {2'b00, int_cnt} + 4'd3;
              end
            end else if (comma_cnt == 4'd2) begin
              if ((rx_data != "A") || status_ok) reject <= 1'b1;
              else                               status_ok <= 1'b1;
            end else if (comma_cnt == 4'd7) begin
              if (is_digit(rx_data)) begin
                if (!seen_dot) begin
                  if (int_cnt == 2'd3) begin
                    reject <= 1'b1;
                  end else begin
                    shadow[int_pos] <= rx_data;
                    int_cnt         <= int_cnt + 2'd1;
                  end
                end else if (frac_cnt != 2'd2) begin
                  shadow[frac_pos] <= rx_data;
                  frac_cnt         <= frac_cnt + 2'd1;
                end
              end else if ((rx_data == ".") && !seen_dot) begin
                seen_dot <= 1'b1;
              end else begin
                reject <= 1'b1;
              end
            end
          end
        end
        CK1: begin
          if (!is_hex(rx_data)) reject <= 1'b1;
          ck_hi <= hex_val(rx_data);
        end
        default: ;
      endcase
    end
  end

  // Output registers, saturating drop counter and acknowledge timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spd0      <= 8'h2E;
      spd1      <= 8'h2E;
      spd2      <= 8'h2E;
      spd3      <= 8'h2E;
      spd4      <= 8'h2E;
      spd5      <= 8'h2E;
      speed_len <= 4'd0;
      drop_cnt  <= '0;
      timer     <= '0;
    end else begin
      if ((state == CK2) && (next_state == ISSUE)) begin
        spd0      <= shadow[0];
        spd1      <= shadow[1];
        spd2      <= shadow[2];
        spd3      <= shadow[3];
        spd4      <= shadow[4];
        spd5      <= shadow[5];
        speed_len <= shadow_len;
      end
      if (drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + DROP_W'(1);
      if (state == WAIT_ACK) timer <= timer + TW'(1);
      else                   timer <= '0;
    end
  end

endmodule
